// File: rtl/dffe_ift_sink_fifo.sv
// Taint-tracking synchronous FIFO fed by the enable flip-flop stage.
// Each stored word carries a label; handshake taint folds into labels and status.
module dffe_ift_sink_fifo #(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned TAINT_W = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [WIDTH-1:0]         D,
  input  logic [TAINT_W-1:0]       D_t,
  input  logic                     WR_EN,
  input  logic [TAINT_W-1:0]       WR_EN_t,
  input  logic                     RD_EN,
  input  logic [TAINT_W-1:0]       RD_EN_t,
  output logic [WIDTH-1:0]         Q,
  output logic [TAINT_W-1:0]       Q_t,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [TAINT_W-1:0]       STAT_t,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [TAINT_W-1:0] lab_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [WIDTH-1:0]   q_q;
  logic [TAINT_W-1:0] q_t_q, stat_t_q, stat_t_d;
  logic               push, pop;

  assign FULL  = (count_q == CntW'(DEPTH));
  assign EMPTY = (count_q == '0);
  assign push  = WR_EN & ~FULL;
  assign pop   = RD_EN & ~EMPTY;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Blocked requests still leak through the handshake, so gate on the raw enables.
  always_comb begin
    stat_t_d = stat_t_q;
    if (WR_EN) stat_t_d = stat_t_d | WR_EN_t;
    if (RD_EN) stat_t_d = stat_t_d | RD_EN_t;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        lab_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      q_q      <= '0;
      q_t_q    <= '0;
      stat_t_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= D;
        lab_q[wr_ptr_q] <= D_t | WR_EN_t;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        q_q      <= mem_q[rd_ptr_q];
        q_t_q    <= lab_q[rd_ptr_q] | RD_EN_t;
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q  <= count_d;
      stat_t_q <= stat_t_d;
    end
  end

  assign Q      = q_q;
  assign Q_t    = q_t_q;
  assign STAT_t = stat_t_q;
  assign COUNT  = count_q;

endmodule

// File: tb/tb_dffe_ift_sink_fifo.sv
// Directed bench for dffe_ift_sink_fifo: ordering, full/empty corners,
// taint propagation and asynchronous reset.
module tb_dffe_ift_sink_fifo;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [1:0]  D = '0;
  logic [31:0] D_t = '0;
  logic        WR_EN = 1'b0;
  logic [31:0] WR_EN_t = '0;
  logic        RD_EN = 1'b0;
  logic [31:0] RD_EN_t = '0;
  logic [1:0]  Q;
  logic [31:0] Q_t;
  logic        FULL, EMPTY;
  logic [31:0] STAT_t;
  logic [2:0]  COUNT;

  int n_cmp = 0;
  int n_fail = 0;

  dffe_ift_sink_fifo #(.WIDTH(2), .TAINT_W(32), .DEPTH(4)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .D       (D),
    .D_t     (D_t),
    .WR_EN   (WR_EN),
    .WR_EN_t (WR_EN_t),
    .RD_EN   (RD_EN),
    .RD_EN_t (RD_EN_t),
    .Q       (Q),
    .Q_t     (Q_t),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
    .STAT_t  (STAT_t),
    .COUNT   (COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_q"}, 64'(Q), 64'h0);
    check({tag, "_q_t"}, 64'(Q_t), 64'h0);
    check({tag, "_count"}, 64'(COUNT), 64'h0);
    check({tag, "_empty"}, 64'(EMPTY), 64'h1);
    check({tag, "_full"}, 64'(FULL), 64'h0);
    check({tag, "_stat_t"}, 64'(STAT_t), 64'h0);
  endtask

  initial begin
    logic [1:0] v [7];
    #1 RST_N = 1'b0;
    #10;
    check_reset_state("reset");
    #1 RST_N = 1'b1;
    tick();

    // 1: single push then pop
    D = 2'b01; D_t = 32'h1; WR_EN = 1'b1; WR_EN_t = 32'h0;
    tick();
    WR_EN = 1'b0; D_t = '0;
    check("t1_count_after_push", 64'(COUNT), 64'h1);
    check("t1_empty_after_push", 64'(EMPTY), 64'h0);
    RD_EN = 1'b1; RD_EN_t = 32'h0;
    tick();
    RD_EN = 1'b0;
    check("t1_q", 64'(Q), 64'h1);
    check("t1_q_t", 64'(Q_t), 64'h1);
    check("t1_empty", 64'(EMPTY), 64'h1);

    // 2: fill, dropped push, drain in order
    WR_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      D = 2'(i);
      tick();
    end
    check("t2_full", 64'(FULL), 64'h1);
    check("t2_count", 64'(COUNT), 64'h4);
    D = 2'b00; D_t = 32'h40;
    tick();
    WR_EN = 1'b0; D_t = '0;
    check("t2_count_after_drop", 64'(COUNT), 64'h4);
    RD_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_pop_q", 64'(Q), 64'(i));
      check("t2_pop_q_t", 64'(Q_t), 64'h0);
    end
    RD_EN = 1'b0;
    check("t2_empty", 64'(EMPTY), 64'h1);

    // 3: simultaneous push/pop at full, then at empty
    WR_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      D = 2'(i);
      tick();
    end
    D = 2'b10; RD_EN = 1'b1;
    tick();
    WR_EN = 1'b0;
    check("t3_full_count", 64'(COUNT), 64'h3);
    check("t3_full_q", 64'(Q), 64'h0);
    check("t3_full_flag", 64'(FULL), 64'h0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("t3_drain_q", 64'(Q), 64'(i));
    end
    check("t3_drained_count", 64'(COUNT), 64'h0);
    WR_EN = 1'b1; D = 2'b01;
    tick();
    WR_EN = 1'b0;
    check("t3_empty_count", 64'(COUNT), 64'h1);
    check("t3_empty_q_hold", 64'(Q), 64'h3);
    tick();
    RD_EN = 1'b0;
    check("t3_empty_pop_q", 64'(Q), 64'h1);
    check("t3_empty_final_count", 64'(COUNT), 64'h0);
    check("t3_stat_t_clean", 64'(STAT_t), 64'h0);

    // 4: label OR of data, write and read taint
    D = 2'b11; D_t = 32'h0; WR_EN = 1'b1; WR_EN_t = 32'h80;
    tick();
    WR_EN = 1'b0; WR_EN_t = '0;
    RD_EN = 1'b1; RD_EN_t = 32'h4;
    tick();
    RD_EN = 1'b0; RD_EN_t = '0;
    check("t4_q", 64'(Q), 64'h3);
    check("t4_q_t", 64'(Q_t), 64'h84);
    check("t4_stat_t", 64'(STAT_t), 64'h84);

    // 5: blocked pop still taints status
    RD_EN = 1'b1; RD_EN_t = 32'h10;
    tick();
    RD_EN = 1'b0; RD_EN_t = '0;
    check("t5_q_hold", 64'(Q), 64'h3);
    check("t5_q_t_hold", 64'(Q_t), 64'h84);
    check("t5_stat_t", 64'(STAT_t), 64'h94);
    check("t5_count", 64'(COUNT), 64'h0);
    tick();
    check("t5_stat_t_sticky", 64'(STAT_t), 64'h94);

    // 6: mid-cycle async reset, then wrap-around traffic
    WR_EN = 1'b1;
    for (int i = 1; i < 4; i++) begin
      D = 2'(i);
      tick();
    end
    WR_EN = 1'b0;
    check("t6_count_pre_reset", 64'(COUNT), 64'h3);
    #3 RST_N = 1'b0;
    #1;
    check_reset_state("t6_async");
    #2 RST_N = 1'b1;
    for (int k = 0; k < 7; k++) v[k] = 2'((k * 3) % 4);
    D = v[0]; D_t = 32'h1; WR_EN = 1'b1;
    tick();
    RD_EN = 1'b1;
    for (int k = 1; k < 7; k++) begin
      D = v[k]; D_t = 32'(k + 1);
      tick();
      check("t6_wrap_q", 64'(Q), 64'(v[k-1]));
      check("t6_wrap_q_t", 64'(Q_t), 64'(k));
      check("t6_wrap_count", 64'(COUNT), 64'h1);
    end
    WR_EN = 1'b0;
    tick();
    RD_EN = 1'b0;
    check("t6_last_q", 64'(Q), 64'(v[6]));
    check("t6_last_q_t", 64'(Q_t), 64'h7);
    check("t6_final_empty", 64'(EMPTY), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
